// File: rtl/audio_in_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_in_deserializer_pkg
// Brief    : Shared audio-link constants and the FIFO fill-level type.
// Revision : 1.0 - initial release
// ============================================================================
package audio_in_deserializer_pkg;

    localparam int AUDIO_DATA_WIDTH_DEF = 32;
    localparam int FIFO_ADDR_WIDTH_DEF  = 7;
    localparam int FIFO_DEPTH_DEF       = 1 << FIFO_ADDR_WIDTH_DEF;

    // {full, used}: the top bit only sets when the FIFO holds exactly DEPTH words.
    typedef logic [FIFO_ADDR_WIDTH_DEF:0] fifo_level_t;

endpackage : audio_in_deserializer_pkg
`default_nettype wire

// File: rtl/audio_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : audio_sync_fifo
// Brief    : Single-clock show-ahead FIFO; head word is visible without a pop.
// Revision : 1.0 - initial release
// ============================================================================
module audio_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic                  fifo_is_empty,
    output logic                  fifo_is_full,
    output logic [ADDR_WIDTH-1:0] words_used,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_do_write;
    logic                  w_do_read;

    assign fifo_is_empty = (r_count == '0);
    assign fifo_is_full  = r_count[ADDR_WIDTH];
    assign words_used    = r_count[ADDR_WIDTH-1:0];
    assign w_do_write    = write_en && !fifo_is_full;
    assign w_do_read     = read_en && !fifo_is_empty;

    // Empty FIFO presents zero so the head output is defined without resetting the array.
    assign read_data = fifo_is_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_write) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_do_read) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_do_write, w_do_read})
                2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

endmodule : audio_sync_fifo
`default_nettype wire

// File: rtl/audio_in_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : audio_in_deserializer
// Brief    : Codec ADC serial-link receiver; buffers stereo pairs in twin FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module audio_in_deserializer
    import audio_in_deserializer_pkg::*;
#(
    parameter int AUDIO_DATA_WIDTH = AUDIO_DATA_WIDTH_DEF,
    parameter int FIFO_ADDR_WIDTH  = FIFO_ADDR_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bit_clk_rising_edge,
    input  logic                        bit_clk_falling_edge,
    input  logic                        left_right_clk_rising_edge,
    input  logic                        left_right_clk_falling_edge,
    input  logic                        serial_audio_in_data,
    input  logic                        left_channel_read_en,
    input  logic                        right_channel_read_en,
    output logic [AUDIO_DATA_WIDTH-1:0] left_channel_data,
    output logic [AUDIO_DATA_WIDTH-1:0] right_channel_data,
    output logic [FIFO_ADDR_WIDTH:0]    left_channel_fifo_read_available,
    output logic [FIFO_ADDR_WIDTH:0]    right_channel_fifo_read_available,
    output logic                        sample_dropped
);

    localparam int CNT_WIDTH = $clog2(AUDIO_DATA_WIDTH + 1);

    logic [AUDIO_DATA_WIDTH-1:0] r_shift_reg;
    logic [AUDIO_DATA_WIDTH-1:0] r_left_hold;
    logic [CNT_WIDTH-1:0]        r_bit_cnt;
    logic                        r_left_started;
    logic [FIFO_ADDR_WIDTH:0]    r_left_avail;
    logic [FIFO_ADDR_WIDTH:0]    r_right_avail;
    logic                        r_sample_dropped;

    logic                        w_commit;
    logic                        w_fifo_write;
    logic                        w_drop;
    logic                        w_left_empty;
    logic                        w_right_empty;
    logic                        w_left_full;
    logic                        w_right_full;
    logic [FIFO_ADDR_WIDTH-1:0]  w_left_used;
    logic [FIFO_ADDR_WIDTH-1:0]  w_right_used;
    logic [AUDIO_DATA_WIDTH-1:0] w_bit_mask;
    logic                        w_unused_ok;

    // Pair commits only once a full left word has been seen since reset.
    assign w_commit     = left_right_clk_rising_edge && r_left_started;
    assign w_fifo_write = w_commit && !w_left_full && !w_right_full;
    assign w_drop       = w_commit && (w_left_full || w_right_full);

    // Incoming bit positioned MSB-first; slots are zero from the frame-start clear.
    assign w_bit_mask = {serial_audio_in_data, {(AUDIO_DATA_WIDTH-1){1'b0}}} >> r_bit_cnt;

    assign w_unused_ok = &{1'b0, bit_clk_falling_edge, w_left_empty, w_right_empty};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift_reg    <= '0;
            r_left_hold    <= '0;
            r_bit_cnt      <= '0;
            r_left_started <= 1'b0;
        end else if (left_right_clk_rising_edge) begin
            r_shift_reg    <= '0;
            r_bit_cnt      <= '0;
            r_left_started <= 1'b1;
        end else if (left_right_clk_falling_edge) begin
            if (r_left_started) begin
                r_left_hold <= r_shift_reg;
            end
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
        end else if (bit_clk_rising_edge && (r_bit_cnt < CNT_WIDTH'(AUDIO_DATA_WIDTH))) begin
            r_shift_reg <= r_shift_reg | w_bit_mask;
            r_bit_cnt   <= r_bit_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left_avail     <= '0;
            r_right_avail    <= '0;
            r_sample_dropped <= 1'b0;
        end else begin
            r_left_avail     <= {w_left_full, w_left_used};
            r_right_avail    <= {w_right_full, w_right_used};
            r_sample_dropped <= w_drop;
        end
    end

    assign left_channel_fifo_read_available  = r_left_avail;
    assign right_channel_fifo_read_available = r_right_avail;
    assign sample_dropped                    = r_sample_dropped;

    audio_sync_fifo #(
        .DATA_WIDTH (AUDIO_DATA_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_left_fifo (
        .clk           (clk),
        .reset         (reset),
        .write_en      (w_fifo_write),
        .write_data    (r_left_hold),
        .read_en       (left_channel_read_en),
        .fifo_is_empty (w_left_empty),
        .fifo_is_full  (w_left_full),
        .words_used    (w_left_used),
        .read_data     (left_channel_data)
    );

    audio_sync_fifo #(
        .DATA_WIDTH (AUDIO_DATA_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_right_fifo (
        .clk           (clk),
        .reset         (reset),
        .write_en      (w_fifo_write),
        .write_data    (r_shift_reg),
        .read_en       (right_channel_read_en),
        .fifo_is_empty (w_right_empty),
        .fifo_is_full  (w_right_full),
        .words_used    (w_right_used),
        .read_data     (right_channel_data)
    );

endmodule : audio_in_deserializer
`default_nettype wire

// File: tb/tb_audio_in_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_in_deserializer
// Brief    : Directed self-checking bench for the audio input deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_in_deserializer;

    logic        clk;
    logic        reset;
    logic        bit_clk_rising_edge;
    logic        bit_clk_falling_edge;
    logic        left_right_clk_rising_edge;
    logic        left_right_clk_falling_edge;
    logic        serial_audio_in_data;
    logic        left_channel_read_en;
    logic        right_channel_read_en;
    logic [31:0] left_channel_data;
    logic [31:0] right_channel_data;
    logic [7:0]  left_channel_fifo_read_available;
    logic [7:0]  right_channel_fifo_read_available;
    logic        sample_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    audio_in_deserializer dut (
        .clk                               (clk),
        .reset                             (reset),
        .bit_clk_rising_edge               (bit_clk_rising_edge),
        .bit_clk_falling_edge              (bit_clk_falling_edge),
        .left_right_clk_rising_edge        (left_right_clk_rising_edge),
        .left_right_clk_falling_edge       (left_right_clk_falling_edge),
        .serial_audio_in_data              (serial_audio_in_data),
        .left_channel_read_en              (left_channel_read_en),
        .right_channel_read_en             (right_channel_read_en),
        .left_channel_data                 (left_channel_data),
        .right_channel_data                (right_channel_data),
        .left_channel_fifo_read_available  (left_channel_fifo_read_available),
        .right_channel_fifo_read_available (right_channel_fifo_read_available),
        .sample_dropped                    (sample_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_audio_in_data = b;
        bit_clk_rising_edge  = 1'b1;
        tick();
        bit_clk_rising_edge  = 1'b0;
        tick();
    endtask

    // Bits beyond the 32nd are driven as 1s and must be ignored.
    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < 32) send_bit(w[31-i]);
            else        send_bit(1'b1);
        end
    endtask

    task automatic lr_fall;
        left_right_clk_falling_edge = 1'b1;
        tick();
        left_right_clk_falling_edge = 1'b0;
    endtask

    task automatic lr_rise;
        left_right_clk_rising_edge = 1'b1;
        tick();
        left_right_clk_rising_edge = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input int n);
        send_word(l, n);
        lr_fall();
        send_word(r, n);
        lr_rise();
        tick();
    endtask

    task automatic pop_both;
        left_channel_read_en  = 1'b1;
        right_channel_read_en = 1'b1;
        tick();
        left_channel_read_en  = 1'b0;
        right_channel_read_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (left_channel_data !== 32'h0) begin n_fail++; $display("FAIL reset_left_data: got %h expected %h", left_channel_data, 32'h0); end
        n_checks++; if (right_channel_data !== 32'h0) begin n_fail++; $display("FAIL reset_right_data: got %h expected %h", right_channel_data, 32'h0); end
        n_checks++; if (left_channel_fifo_read_available !== 8'd0) begin n_fail++; $display("FAIL reset_left_avail: got %0d expected 0", left_channel_fifo_read_available); end
        n_checks++; if (right_channel_fifo_read_available !== 8'd0) begin n_fail++; $display("FAIL reset_right_avail: got %0d expected 0", right_channel_fifo_read_available); end
        n_checks++; if (sample_dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped: got %b expected 0", sample_dropped); end
        reset = 1'b0;
        tick();
        // Partial word interrupted by reset
        lr_rise();
        send_word(32'hFFFF_FFFF, 5);
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        // First frame after reset is partial and must not be committed
        send_word(32'hFFFF_FFFF, 7);
        lr_fall();
        send_word(32'hFFFF_FFFF, 9);
        lr_rise();
        tick();
        tick();
        n_checks++; if (left_channel_fifo_read_available !== 8'd0) begin n_fail++; $display("FAIL first_partial_not_committed: got %0d expected 0", left_channel_fifo_read_available); end
        send_word(32'hA5A5_A5A5, 32);
        lr_fall();
        send_word(32'h5A5A_5A5A, 32);
        left_right_clk_rising_edge = 1'b1;
        tick();
        left_right_clk_rising_edge = 1'b0;
        n_checks++; if (left_channel_fifo_read_available !== 8'd0) begin n_fail++; $display("FAIL avail_latency_1cycle: got %0d expected 0", left_channel_fifo_read_available); end
        tick();
        n_checks++; if (left_channel_fifo_read_available !== 8'd1) begin n_fail++; $display("FAIL avail_latency_2cycle_left: got %0d expected 1", left_channel_fifo_read_available); end
        n_checks++; if (right_channel_fifo_read_available !== 8'd1) begin n_fail++; $display("FAIL avail_latency_2cycle_right: got %0d expected 1", right_channel_fifo_read_available); end
        n_checks++; if (left_channel_data !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL first_left_word: got %h expected %h", left_channel_data, 32'hA5A5_A5A5); end
        n_checks++; if (right_channel_data !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL first_right_word: got %h expected %h", right_channel_data, 32'h5A5A_5A5A); end
        pop_both();
        tick();
        n_checks++; if (left_channel_fifo_read_available !== 8'd0) begin n_fail++; $display("FAIL first_pop_avail: got %0d expected 0", left_channel_fifo_read_available); end
    endtask

    task automatic test_short_long;
        send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 24);
        n_checks++; if (left_channel_data !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL short_left: got %h expected %h", left_channel_data, 32'hFFFF_FF00); end
        n_checks++; if (right_channel_data !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL short_right: got %h expected %h", right_channel_data, 32'hFFFF_FF00); end
        pop_both();
        send_pair(32'h1234_5678, 32'h8765_4321, 40);
        n_checks++; if (left_channel_data !== 32'h1234_5678) begin n_fail++; $display("FAIL long_left: got %h expected %h", left_channel_data, 32'h1234_5678); end
        n_checks++; if (right_channel_data !== 32'h8765_4321) begin n_fail++; $display("FAIL long_right: got %h expected %h", right_channel_data, 32'h8765_4321); end
        n_checks++; if (left_channel_fifo_read_available !== 8'd1) begin n_fail++; $display("FAIL long_avail: got %0d expected 1", left_channel_fifo_read_available); end
        pop_both();
        tick();
    endtask

    task automatic test_coincident;
        send_word(32'hCAFE_F00D, 32);
        left_right_clk_falling_edge = 1'b1;
        bit_clk_rising_edge         = 1'b1;
        serial_audio_in_data        = 1'b1;
        tick();
        left_right_clk_falling_edge = 1'b0;
        bit_clk_rising_edge         = 1'b0;
        tick();
        send_word(32'h0F0F_0F0F, 32);
        left_right_clk_rising_edge = 1'b1;
        bit_clk_rising_edge        = 1'b1;
        serial_audio_in_data       = 1'b1;
        tick();
        left_right_clk_rising_edge = 1'b0;
        bit_clk_rising_edge        = 1'b0;
        tick();
        n_checks++; if (left_channel_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL coincident_left: got %h expected %h", left_channel_data, 32'hCAFE_F00D); end
        n_checks++; if (right_channel_data !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL coincident_fall_right: got %h expected %h", right_channel_data, 32'h0F0F_0F0F); end
        pop_both();
        send_pair(32'h0000_0001, 32'h0000_0002, 32);
        n_checks++; if (left_channel_data !== 32'h0000_0001) begin n_fail++; $display("FAIL coincident_rise_left: got %h expected %h", left_channel_data, 32'h0000_0001); end
        n_checks++; if (right_channel_data !== 32'h0000_0002) begin n_fail++; $display("FAIL coincident_rise_right: got %h expected %h", right_channel_data, 32'h0000_0002); end
        pop_both();
        tick();
    endtask

    task automatic test_overflow;
        logic [31:0] v;
        int          seen_drop;
        seen_drop = 0;
        for (int i = 0; i < 128; i++) begin
            v = 32'(i);
            send_pair(v, ~v, 32);
            if (sample_dropped !== 1'b0) seen_drop++;
        end
        n_checks++; if (seen_drop != 0) begin n_fail++; $display("FAIL fill_no_drop: got %0d drops expected 0", seen_drop); end
        n_checks++; if (left_channel_fifo_read_available !== 8'h80) begin n_fail++; $display("FAIL full_left_avail: got %h expected 80", left_channel_fifo_read_available); end
        n_checks++; if (right_channel_fifo_read_available !== 8'h80) begin n_fail++; $display("FAIL full_right_avail: got %h expected 80", right_channel_fifo_read_available); end
        send_word(32'hDEAD_BEEF, 32);
        lr_fall();
        send_word(32'hBEEF_DEAD, 32);
        n_checks++; if (sample_dropped !== 1'b0) begin n_fail++; $display("FAIL drop_before_edge: got %b expected 0", sample_dropped); end
        left_right_clk_rising_edge = 1'b1;
        tick();
        left_right_clk_rising_edge = 1'b0;
        n_checks++; if (sample_dropped !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b expected 1", sample_dropped); end
        tick();
        n_checks++; if (sample_dropped !== 1'b0) begin n_fail++; $display("FAIL drop_single_cycle: got %b expected 0", sample_dropped); end
        n_checks++; if (left_channel_fifo_read_available !== 8'h80) begin n_fail++; $display("FAIL drop_left_avail: got %h expected 80", left_channel_fifo_read_available); end
        n_checks++; if (right_channel_fifo_read_available !== 8'h80) begin n_fail++; $display("FAIL drop_right_avail: got %h expected 80", right_channel_fifo_read_available); end
        for (int i = 0; i < 128; i++) begin
            v = 32'(i);
            n_checks++;
            if (left_channel_data !== v || right_channel_data !== ~v) begin
                n_fail++;
                $display("FAIL full_contents[%0d]: got %h/%h expected %h/%h", i, left_channel_data, right_channel_data, v, ~v);
            end
            pop_both();
        end
        tick();
        n_checks++; if (left_channel_fifo_read_available !== 8'd0) begin n_fail++; $display("FAIL drain_avail: got %0d expected 0", left_channel_fifo_read_available); end
        n_checks++; if (left_channel_data !== 32'h0) begin n_fail++; $display("FAIL drain_left_data: got %h expected 0", left_channel_data); end
    endtask

    task automatic test_reads;
        left_channel_read_en = 1'b1;
        tick();
        left_channel_read_en = 1'b0;
        tick();
        tick();
        n_checks++; if (left_channel_fifo_read_available !== 8'd0) begin n_fail++; $display("FAIL empty_pop_left: got %0d expected 0", left_channel_fifo_read_available); end
        for (int i = 0; i < 5; i++) send_pair(32'h100 + 32'(i), 32'h200 + 32'(i), 32);
        n_checks++; if (left_channel_fifo_read_available !== 8'd5) begin n_fail++; $display("FAIL five_avail: got %0d expected 5", left_channel_fifo_read_available); end
        n_checks++; if (right_channel_fifo_read_available !== 8'd5) begin n_fail++; $display("FAIL five_avail_right: got %0d expected 5", right_channel_fifo_read_available); end
        send_word(32'h105, 32);
        lr_fall();
        send_word(32'h205, 32);
        left_right_clk_rising_edge = 1'b1;
        left_channel_read_en       = 1'b1;
        right_channel_read_en      = 1'b1;
        tick();
        left_right_clk_rising_edge = 1'b0;
        left_channel_read_en       = 1'b0;
        right_channel_read_en      = 1'b0;
        n_checks++; if (left_channel_data !== 32'h101) begin n_fail++; $display("FAIL concurrent_head: got %h expected %h", left_channel_data, 32'h101); end
        tick();
        n_checks++; if (left_channel_fifo_read_available !== 8'd5) begin n_fail++; $display("FAIL concurrent_left_avail: got %0d expected 5", left_channel_fifo_read_available); end
        n_checks++; if (right_channel_fifo_read_available !== 8'd5) begin n_fail++; $display("FAIL concurrent_right_avail: got %0d expected 5", right_channel_fifo_read_available); end
        for (int i = 1; i <= 5; i++) begin
            n_checks++;
            if (left_channel_data !== 32'h100 + 32'(i) || right_channel_data !== 32'h200 + 32'(i)) begin
                n_fail++;
                $display("FAIL read_order[%0d]: got %h/%h expected %h/%h", i, left_channel_data, right_channel_data, 32'h100 + 32'(i), 32'h200 + 32'(i));
            end
            pop_both();
        end
        tick();
        n_checks++; if (left_channel_fifo_read_available !== 8'd0) begin n_fail++; $display("FAIL reads_drained: got %0d expected 0", left_channel_fifo_read_available); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 10; i++) send_pair(32'h1000 + 32'(i), 32'h2000 + 32'(i), 32);
        n_checks++; if (left_channel_fifo_read_available !== 8'd10) begin n_fail++; $display("FAIL ten_avail: got %0d expected 10", left_channel_fifo_read_available); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (left_channel_fifo_read_available !== 8'd0) begin n_fail++; $display("FAIL async_left_avail: got %0d expected 0", left_channel_fifo_read_available); end
        n_checks++; if (right_channel_fifo_read_available !== 8'd0) begin n_fail++; $display("FAIL async_right_avail: got %0d expected 0", right_channel_fifo_read_available); end
        n_checks++; if (left_channel_data !== 32'h0) begin n_fail++; $display("FAIL async_left_data: got %h expected 0", left_channel_data); end
        n_checks++; if (right_channel_data !== 32'h0) begin n_fail++; $display("FAIL async_right_data: got %h expected 0", right_channel_data); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset                       = 1'b1;
        bit_clk_rising_edge         = 1'b0;
        bit_clk_falling_edge        = 1'b0;
        left_right_clk_rising_edge  = 1'b0;
        left_right_clk_falling_edge = 1'b0;
        serial_audio_in_data        = 1'b0;
        left_channel_read_en        = 1'b0;
        right_channel_read_en       = 1'b0;
        test_reset();
        test_short_long();
        test_coincident();
        test_overflow();
        test_reads();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_audio_in_deserializer
`default_nettype wire
